// File: rtl/rvc_asap_cr_mem_if.sv
// D_MEM-style bus between the core (master) and a memory-mapped responder (slave).
// q is the registered read data returned one cycle after a read request.
interface rvc_asap_cr_mem_if;
    logic [31:0] data;
    logic [31:0] address;
    logic [3:0]  byteena;
    logic        wren;
    logic        rden;
    logic [31:0] q;

    modport master (output data, address, byteena, wren, rden, input q);
    modport slave  (input data, address, byteena, wren, rden, output q);
endinterface

// File: rtl/rvc_asap_cr_mem.sv
// Control-register window mapping board I/O (7-seg, LEDs, buttons, switches) onto the D_MEM bus.
// Optional button debouncing is enabled by defining RVC_CR_DEBOUNCE_EN.
module rvc_asap_cr_mem #(
    parameter logic [31:0] CR_BASE         = 32'h0040_0000,
    parameter int          DEBOUNCE_CYCLES = 50000
) (
    input  logic              Clock,
    input  logic              Rst,
    rvc_asap_cr_mem_if.slave  bus,
    input  logic              Button_0,
    input  logic              Button_1,
    input  logic [9:0]        Switch,
    output logic [7:0]        SEG7_0,
    output logic [7:0]        SEG7_1,
    output logic [7:0]        SEG7_2,
    output logic [7:0]        SEG7_3,
    output logic [7:0]        SEG7_4,
    output logic [7:0]        SEG7_5,
    output logic [9:0]        LED
);
    localparam logic [19:0] CR_PAGE = CR_BASE[31:12];
    localparam logic [9:0]  W_LED   = 10'd6;
    localparam logic [9:0]  W_BTN0  = 10'd7;
    localparam logic [9:0]  W_BTN1  = 10'd8;
    localparam logic [9:0]  W_SW    = 10'd9;

    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic        hit;
    logic        wr_hit;
    logic [9:0]  word;
    logic [7:0]  seg [6];
    logic [9:0]  led;
    logic [1:0]  btn_meta;
    logic [1:0]  btn_sync;
    logic [1:0]  btn_level;
    logic [1:0]  btn_prev;
    logic [1:0]  btn_latch;
    logic [1:0]  btn_rise;
    logic [1:0]  btn_clr;
    logic [9:0]  sw_meta;
    logic [9:0]  sw_sync;
    logic [31:0] rdata;
    logic [31:0] q_r;
    logic        unused_bus_bits;

    assign hit    = (bus.address[31:12] == CR_PAGE);
    assign word   = bus.address[11:2];
    assign wr_hit = bus.wren && hit;

    // Byte-lane and address bits that no register implements.
    assign unused_bus_bits = ^{bus.data[31:10], bus.address[1:0], bus.byteena[3:2]};

    // NOTE: every flop here uses <= so all registers sample the same pre-edge values.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_prev <= '0;
        end else begin
            btn_meta <= {Button_1, Button_0};
            btn_sync <= btn_meta;
            sw_meta  <= Switch;
            sw_sync  <= sw_meta;
            btn_prev <= btn_level;
        end
    end

`ifdef RVC_CR_DEBOUNCE_EN
    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] db_cnt [2];

    // The accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            btn_level <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_sync[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX - 1'b1) begin
                    btn_level[i] <= ~btn_level[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign btn_level = btn_sync;
`endif

    assign btn_rise = btn_level & ~btn_prev;

    // NOTE: defaults first so no path through the block leaves a variable unassigned (no latches).
    always_comb begin
        btn_clr = '0;
        if (wr_hit && bus.byteena[0] && bus.data[1]) begin
            btn_clr[0] = (word == W_BTN0);
            btn_clr[1] = (word == W_BTN1);
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 6; i++) begin
            if (word == 10'(i)) rdata[7:0] = seg[i];
        end
        case (word)
            W_LED:   rdata[9:0] = led;
            W_BTN0:  rdata[1:0] = {btn_latch[0], btn_level[0]};
            W_BTN1:  rdata[1:0] = {btn_latch[1], btn_level[1]};
            W_SW:    rdata[9:0] = sw_sync;
            default: ;
        endcase
    end

    // NOTE: the small segment array is reset like any other register so the pins come up dark.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < 6; i++) seg[i] <= '0;
            led       <= '0;
            btn_latch <= '0;
            q_r       <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (wr_hit && bus.byteena[0] && word == 10'(i)) seg[i] <= bus.data[7:0];
            end
            if (wr_hit && word == W_LED) begin
                if (bus.byteena[0]) led[7:0] <= bus.data[7:0];
                if (bus.byteena[1]) led[9:8] <= bus.data[9:8];
            end
            // A new press outranks a clear landing in the same cycle.
            btn_latch <= btn_rise | (btn_latch & ~btn_clr);
            q_r       <= (bus.rden && hit) ? rdata : '0;
        end
    end

    assign bus.q  = q_r;
    assign SEG7_0 = seg[0];
    assign SEG7_1 = seg[1];
    assign SEG7_2 = seg[2];
    assign SEG7_3 = seg[3];
    assign SEG7_4 = seg[4];
    assign SEG7_5 = seg[5];
    assign LED    = led;
endmodule

// File: tb/tb_rvc_asap_cr_mem.sv
// Self-checking bench for rvc_asap_cr_mem: directed steps plus a randomized register-traffic phase
// compared against a register-map model. Define RVC_CR_DEBOUNCE_EN to exercise debouncing.
module tb_rvc_asap_cr_mem;
    localparam logic [31:0] CR_BASE = 32'h0040_0000;
    localparam logic [19:0] CR_PAGE = CR_BASE[31:12];
`ifdef RVC_CR_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 50000;
`endif

    logic       Clock = 1'b0;
    logic       Rst   = 1'b0;
    logic       Button_0, Button_1;
    logic [9:0] Switch;
    logic [7:0] SEG7_0, SEG7_1, SEG7_2, SEG7_3, SEG7_4, SEG7_5;
    logic [9:0] LED;

    rvc_asap_cr_mem_if bus ();

    rvc_asap_cr_mem #(.CR_BASE(CR_BASE), .DEBOUNCE_CYCLES(DB)) dut (
        .Clock    (Clock),
        .Rst      (Rst),
        .bus      (bus),
        .Button_0 (Button_0),
        .Button_1 (Button_1),
        .Switch   (Switch),
        .SEG7_0   (SEG7_0),
        .SEG7_1   (SEG7_1),
        .SEG7_2   (SEG7_2),
        .SEG7_3   (SEG7_3),
        .SEG7_4   (SEG7_4),
        .SEG7_5   (SEG7_5),
        .LED      (LED)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Register-map model: what software should see at each offset.
    logic [7:0] m_seg [6];
    logic [9:0] m_led;
    logic [1:0] m_latch;
    logic [1:0] m_level;
    logic [9:0] m_sw;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a[31:12] == CR_PAGE) begin
            case (int'(a[11:2]))
                0, 1, 2, 3, 4, 5: r[7:0] = m_seg[a[4:2]];
                6: r[9:0] = m_led;
                7: r[1:0] = {m_latch[0], m_level[0]};
                8: r[1:0] = {m_latch[1], m_level[1]};
                9: r[9:0] = m_sw;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        if (a[31:12] != CR_PAGE) return;
        w = model_read(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        case (int'(a[11:2]))
            0, 1, 2, 3, 4, 5: m_seg[a[4:2]] = w[7:0];
            6: m_led = w[9:0];
            7: if (be[0] && d[1]) m_latch[0] = 1'b0;
            8: if (be[0] && d[1]) m_latch[1] = 1'b0;
            default: ;
        endcase
    endtask

    task automatic check_pins(input string tag);
        check({tag, " pins"},
              {6'b0, SEG7_5, SEG7_4, SEG7_3, SEG7_2, SEG7_1, SEG7_0, LED},
              {6'b0, m_seg[5], m_seg[4], m_seg[3], m_seg[2], m_seg[1], m_seg[0], m_led});
    endtask

    // One bus cycle launched at a falling edge; q and pins are sampled at the next falling edge.
    task automatic xfer(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input string tag);
        logic [31:0] exp_q;
        exp_q = rd ? model_read(a) : 32'h0;
        if (wr) model_write(a, d, be);
        bus.wren    = wr;
        bus.rden    = rd;
        bus.address = a;
        bus.data    = d;
        bus.byteena = be;
        @(negedge Clock);
        bus.wren = 1'b0;
        bus.rden = 1'b0;
        check({tag, " q"}, {32'h0, bus.q}, {32'h0, exp_q});
        check_pins(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, d;
        logic [3:0]  be;
        logic        wr, rd;
        int          sel;

        bus.wren = 1'b0; bus.rden = 1'b0; bus.address = '0; bus.data = '0; bus.byteena = '0;
        Button_0 = 1'b0; Button_1 = 1'b0; Switch = '0;
        for (int i = 0; i < 6; i++) m_seg[i] = '0;
        m_led = '0; m_latch = '0; m_level = '0; m_sw = '0;

        // Reset state
        repeat (3) @(negedge Clock);
        check("reset q", {32'h0, bus.q}, 64'h0);
        check_pins("reset");
        Rst = 1'b1;
        xfer(1'b0, 1'b1, CR_BASE + 32'h18, 32'h0, 4'h0, "reset rd led");
        check("reset led read", {32'h0, bus.q}, 64'h0);

        // Byte-enabled writes
        xfer(1'b1, 1'b0, CR_BASE + 32'h08, 32'h0000_00A5, 4'b0001, "wr seg2");
        check("seg2 pin", {56'h0, SEG7_2}, 64'hA5);
        xfer(1'b1, 1'b0, CR_BASE + 32'h18, 32'hFFFF_FF3C, 4'b0010, "wr led hi");
        check("led pin", {54'h0, LED}, 64'h300);
        xfer(1'b0, 1'b1, CR_BASE + 32'h18, 32'h0, 4'h0, "rd led");
        check("led read", {32'h0, bus.q}, 64'h300);

        // Switch synchronizer and read-only protection
        Switch = 10'h2AA;
        repeat (3) @(negedge Clock);
        m_sw = 10'h2AA;
        xfer(1'b0, 1'b1, CR_BASE + 32'h24, 32'h0, 4'h0, "rd sw");
        check("sw read", {32'h0, bus.q}, 64'h2AA);
        xfer(1'b1, 1'b0, CR_BASE + 32'h24, 32'hFFFF_FFFF, 4'hF, "wr sw");
        xfer(1'b0, 1'b1, CR_BASE + 32'h24, 32'h0, 4'h0, "rd sw again");
        check("sw read-only", {32'h0, bus.q}, 64'h2AA);

`ifndef RVC_CR_DEBOUNCE_EN
        // Press latch: set, clear, and set winning over a simultaneous clear
        Button_0 = 1'b1;
        repeat (5) @(negedge Clock);
        Button_0 = 1'b0;
        repeat (4) @(negedge Clock);
        m_latch[0] = 1'b1;
        xfer(1'b0, 1'b1, CR_BASE + 32'h1C, 32'h0, 4'h0, "rd btn0");
        check("btn0 latched", {32'h0, bus.q}, 64'h2);
        xfer(1'b1, 1'b0, CR_BASE + 32'h1C, 32'h2, 4'b0001, "clr btn0");
        xfer(1'b0, 1'b1, CR_BASE + 32'h1C, 32'h0, 4'h0, "rd btn0 clr");
        check("btn0 cleared", {32'h0, bus.q}, 64'h0);
        Button_0 = 1'b1;
        repeat (2) @(negedge Clock);
        xfer(1'b1, 1'b0, CR_BASE + 32'h1C, 32'h2, 4'b0001, "clr on rise");
        m_latch[0] = 1'b1;
        m_level[0] = 1'b1;
        xfer(1'b0, 1'b1, CR_BASE + 32'h1C, 32'h0, 4'h0, "rd btn0 held");
        check("btn0 level+latch", {32'h0, bus.q}, 64'h3);
        Button_0 = 1'b0;
        repeat (4) @(negedge Clock);
        m_level[0] = 1'b0;
        xfer(1'b0, 1'b1, CR_BASE + 32'h1C, 32'h0, 4'h0, "rd btn0 set wins");
        check("btn0 set wins", {32'h0, bus.q}, 64'h2);
        xfer(1'b1, 1'b0, CR_BASE + 32'h1C, 32'h2, 4'b0001, "clr btn0 end");
`else
        // Debounce: a short glitch is ignored, a long pulse is accepted
        Button_1 = 1'b1;
        repeat (3) @(negedge Clock);
        Button_1 = 1'b0;
        repeat (8) @(negedge Clock);
        xfer(1'b0, 1'b1, CR_BASE + 32'h20, 32'h0, 4'h0, "rd btn1 glitch");
        check("btn1 glitch ignored", {32'h0, bus.q}, 64'h0);
        Button_1 = 1'b1;
        repeat (8) @(negedge Clock);
        m_level[1] = 1'b1;
        m_latch[1] = 1'b1;
        xfer(1'b0, 1'b1, CR_BASE + 32'h20, 32'h0, 4'h0, "rd btn1 pulse");
        check("btn1 during pulse", {32'h0, bus.q}, 64'h3);
        @(negedge Clock);
        Button_1 = 1'b0;
        repeat (10) @(negedge Clock);
        m_level[1] = 1'b0;
        xfer(1'b0, 1'b1, CR_BASE + 32'h20, 32'h0, 4'h0, "rd btn1 after");
        check("btn1 after release", {32'h0, bus.q}, 64'h2);
        xfer(1'b1, 1'b0, CR_BASE + 32'h20, 32'h2, 4'b0001, "clr btn1");
`endif

        // Same-cycle read and write, then misses
        xfer(1'b1, 1'b0, CR_BASE + 32'h18, 32'h001, 4'b0011, "led=1");
        xfer(1'b1, 1'b1, CR_BASE + 32'h18, 32'h3FF, 4'b0011, "rw same");
        check("read-before-write", {32'h0, bus.q}, 64'h001);
        xfer(1'b0, 1'b1, CR_BASE + 32'h18, 32'h0, 4'h0, "rd after rw");
        check("new value visible", {32'h0, bus.q}, 64'h3FF);
        xfer(1'b0, 1'b1, CR_BASE + 32'h100, 32'h0, 4'h0, "rd unmapped");
        check("unmapped read", {32'h0, bus.q}, 64'h0);
        xfer(1'b1, 1'b0, 32'h0000_0018, 32'h0, 4'hF, "wr miss");
        check("miss write ignored", {54'h0, LED}, 64'h3FF);

        // Randomized traffic over the whole window and its neighbours
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0)
                a = {CR_PAGE + 20'd1, 12'($urandom_range(0, 40))};
            else if (sel == 1)
                a = CR_BASE + 32'($urandom_range(40, 4095));
            else
                a = CR_BASE + 32'($urandom_range(0, 10) * 4 + $urandom_range(0, 3));
            d  = $urandom;
            be = 4'($urandom);
            wr = 1'($urandom);
            rd = 1'($urandom);
            xfer(wr, rd, a, d, be, "rand");
        end

        // Reset landing on a pending access drops it
        bus.wren = 1'b1; bus.rden = 1'b1;
        bus.address = CR_BASE + 32'h18; bus.data = 32'h155; bus.byteena = 4'hF;
        #2 Rst = 1'b0;
        @(negedge Clock);
        bus.wren = 1'b0; bus.rden = 1'b0;
        for (int i = 0; i < 6; i++) m_seg[i] = '0;
        m_led = '0; m_latch = '0; m_level = '0;
        check("mid-access reset q", {32'h0, bus.q}, 64'h0);
        check_pins("mid-access reset");
        Rst = 1'b1;
        xfer(1'b0, 1'b1, CR_BASE + 32'h18, 32'h0, 4'h0, "rd led post reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
